// File: rtl/minitb_ahb_slave_if.sv
// AHB-lite bus bundle between the miniTB master and minitb_ahb_slave.
// The hresp wires exist only when MINITB_AHB_SLAVE_HRESP_EN is defined.
interface minitb_ahb_slave_if #(
    parameter int addrWidth = 8,
    parameter int dataWidth = 32
);
    logic                 hsel;
    logic [1:0]           htrans;
    logic [addrWidth-1:0] haddr;
    logic                 hwrite;
    logic [dataWidth-1:0] hwdata;
    logic [dataWidth-1:0] hrdata;
    logic                 hready;
`ifdef MINITB_AHB_SLAVE_HRESP_EN
    logic [1:0]           hresp;

    modport master (output hsel, htrans, haddr, hwrite, hwdata,
                    input  hrdata, hready, hresp);
    modport slave  (input  hsel, htrans, haddr, hwrite, hwdata,
                    output hrdata, hready, hresp);
`else
    modport master (output hsel, htrans, haddr, hwrite, hwdata,
                    input  hrdata, hready);
    modport slave  (input  hsel, htrans, haddr, hwrite, hwdata,
                    output hrdata, hready);
`endif
endinterface

// File: rtl/minitb_ahb_slave.sv
// AHB-lite responder backed by a small register file, with WAIT_STATES wait cycles per data phase.
// Define MINITB_AHB_SLAVE_HRESP_EN to get hresp and a two-cycle ERROR response for out-of-range indices.
module minitb_ahb_slave #(
    parameter int addrWidth   = 8,
    parameter int dataWidth   = 32,
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic              hclk,
    input  logic              hresetn,
    minitb_ahb_slave_if.slave bus
);
    localparam int                 IDX_W         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [addrWidth:0] DEPTH_W       = (addrWidth + 1)'(DEPTH);
    localparam logic [3:0]         CNT_LOAD      = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [1:0]         HTRANS_NONSEQ = 2'b10;

`ifdef MINITB_AHB_SLAVE_HRESP_EN
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DONE, ST_ERR1, ST_ERR2} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;
`endif

    state_t               state_q;
    state_t               state_d;
    logic [dataWidth-1:0] mem [DEPTH];
    logic [addrWidth-1:0] addr_q;
    logic                 write_q;
    logic                 pend_q;
    logic [3:0]           cnt_q;
    logic [dataWidth-1:0] hrdata_q;
    logic                 hready_int;
`ifdef MINITB_AHB_SLAVE_HRESP_EN
    logic [1:0]           hresp_int;
`endif

    logic                 accept;
    logic                 commit;
    logic                 rd_enter;
    logic                 fwd;
    logic                 rd_write;
    logic [addrWidth-1:0] rd_idx;
    logic [dataWidth-1:0] rd_word;

    function automatic logic is_oor(input logic [addrWidth-1:0] idx);
        return {1'b0, idx} >= DEPTH_W;
    endfunction

    assign accept = hready_int && bus.hsel && (bus.htrans == HTRANS_NONSEQ);

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_t start_st;
        if (WAIT_STATES > 0)
            start_st = ST_WAIT;
`ifdef MINITB_AHB_SLAVE_HRESP_EN
        else if (is_oor(bus.haddr))
            start_st = ST_ERR1;
`endif
        else
            start_st = ST_DONE;

        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = start_st;
`ifdef MINITB_AHB_SLAVE_HRESP_EN
            ST_WAIT: if (cnt_q == 4'd0) state_d = is_oor(addr_q) ? ST_ERR1 : ST_DONE;
`else
            ST_WAIT: if (cnt_q == 4'd0) state_d = ST_DONE;
`endif
            ST_DONE: state_d = accept ? start_st : ST_IDLE;
`ifdef MINITB_AHB_SLAVE_HRESP_EN
            ST_ERR1: state_d = ST_ERR2;
            ST_ERR2: state_d = accept ? start_st : ST_IDLE;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        hready_int = 1'b1;
`ifdef MINITB_AHB_SLAVE_HRESP_EN
        hresp_int  = RESP_OKAY;
`endif
        case (state_q)
            ST_WAIT: hready_int = 1'b0;
`ifdef MINITB_AHB_SLAVE_HRESP_EN
            ST_ERR1: begin
                hready_int = 1'b0;
                hresp_int  = RESP_ERROR;
            end
            ST_ERR2: hresp_int = RESP_ERROR;
`endif
            default: ;
        endcase
    end

    // The counter reloads on every accept and only runs down while waiting.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            pend_q  <= 1'b0;
            cnt_q   <= 4'd0;
        end else if (accept) begin
            addr_q  <= bus.haddr;
            write_q <= bus.hwrite;
            pend_q  <= 1'b1;
            cnt_q   <= CNT_LOAD;
        end else begin
            if (hready_int)
                pend_q <= 1'b0;
            if ((state_q == ST_WAIT) && (cnt_q != 4'd0))
                cnt_q <= cnt_q - 4'd1;
        end
    end

    assign commit = (state_q == ST_DONE) && pend_q && write_q && !is_oor(addr_q);

    // With zero wait states a read can be accepted on the very edge that
    // commits the previous write, so it must see the incoming hwdata.
    assign rd_idx   = accept ? bus.haddr  : addr_q;
    assign rd_write = accept ? bus.hwrite : write_q;
    assign rd_enter = (state_d == ST_DONE) && !rd_write;
    assign fwd      = commit && (addr_q == rd_idx);

    always_comb begin
        rd_word = '0;
        if (fwd)
            rd_word = bus.hwdata;
        else if (!is_oor(rd_idx))
            rd_word = mem[rd_idx[IDX_W-1:0]];
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (commit) begin
            mem[addr_q[IDX_W-1:0]] <= bus.hwdata;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn)      hrdata_q <= '0;
        else if (rd_enter) hrdata_q <= rd_word;
    end

    assign bus.hready = hready_int;
    assign bus.hrdata = hrdata_q;
`ifdef MINITB_AHB_SLAVE_HRESP_EN
    assign bus.hresp  = hresp_int;
`endif

endmodule

// File: doc/minitb_ahb_slave.md
# minitb_ahb_slave

AHB-lite responder that answers the transfers issued by the miniTB AHB master interface, backed by a small internal register file. It decodes NONSEQ address phases, completes write and read data phases, and inserts a parameterised number of wait states by holding `hready` low. It sits on the testbench side of a single-master, single-slave bus, directly facing the master's `hready`/`hrdata` inputs.

## Interface
- `addrWidth`, 8: width of `haddr`; `haddr` is a word index, not a byte address.
- `dataWidth`, 32: width of `hwdata`/`hrdata`.
- `DEPTH`, 16: number of storage words; legal index range 0..DEPTH-1, with DEPTH <= 2**addrWidth.
- `WAIT_STATES`, 0: wait cycles inserted per data phase, 0..15.
- `hclk`  in  1  bus clock; all logic on the rising edge.
- `hresetn`  in  1  asynchronous, active-low reset.
- `hsel`  in  1  slave select; a transfer is accepted only when high.
- `htrans`  in  2  IDLE=2'b00, NONSEQ=2'b10; BUSY and SEQ are treated as IDLE.
- `haddr`  in  addrWidth  transfer word index.
- `hwrite`  in  1  1 = write, 0 = read.
- `hwdata`  in  dataWidth  write data, sampled in the data phase.
- `hrdata`  out  dataWidth  read data, valid in the data-phase cycle with `hready`=1.
- `hready`  out  1  transfer-done / address-accept.
- `hresp`  out  2  present only with `MINITB_AHB_SLAVE_HRESP_EN`; OKAY=2'b00, ERROR=2'b01.

## Operation
- Reset values: `hready`=1, `hrdata`=0, `hresp`=OKAY, FSM=IDLE, all storage words=0.
- Address accept: on a rising edge with `hready`=1, `hsel`=1 and `htrans`=NONSEQ, latch `haddr`, `hwrite` and a valid flag. This begins the data phase. Otherwise no transfer is pending.
- FSM states:
  - IDLE: no data phase.
  - WAIT: counting wait states, `hready`=0.
  - DONE: final data cycle, `hready`=1.
  - ERR1/ERR2: exist only with the macro.
- Transitions:
  - accept with WAIT_STATES=0 -> DONE.
  - accept with WAIT_STATES>0 -> WAIT, counter loaded with WAIT_STATES-1.
  - WAIT with counter 0 -> DONE; otherwise decrement.
  - DONE -> DONE on a new accept (back-to-back, WAIT_STATES=0), WAIT on a new accept (WAIT_STATES>0), else IDLE.
- Write commit: on the edge that ends a write data phase (`hready`=1), store `hwdata` into the latched index.
- Read data: `hrdata` is registered on the edge that enters DONE and holds until the next read completes.
- Forwarding: if a read enters DONE on the same edge that commits a write to the same index, `hrdata` takes the incoming `hwdata`, not the stale word.
- Out-of-range index (>= DEPTH), macro off: writes are dropped, reads return 0, and the response is OKAY.
- While `hready`=0 the master holds its next address phase. No new address is sampled until `hready` returns to 1.

## Timing
- Latency, address-accept edge to data-phase completion: WAIT_STATES+1 cycles. With WAIT_STATES=0, one transfer completes every cycle.
- Pipelined overlap: the next address phase is accepted on the same edge that completes the current data phase.
- Write followed immediately by a read of the same index returns the new data with zero bubbles.
- IDLE transfers and `hsel`=0 cycles leave `hready`=1 and cause no storage change.
- `hresetn` asserted mid-transfer: immediately return to reset values, and discard any pending write and any latched address. The first edge after deassertion may accept a new address.

## Configuration
- Macro `MINITB_AHB_SLAVE_HRESP_EN`.
- Defined:
  - The `hresp` port exists and the FSM gains ERR1/ERR2.
  - An out-of-range transfer enters ERR1 after the wait states: `hready`=0, `hresp`=ERROR.
  - It then enters ERR2: `hready`=1, `hresp`=ERROR.
  - It then returns to IDLE, or accepts a new address on the ERR2 edge.
  - Error writes are dropped; error reads leave `hrdata` unchanged.
- Undefined: no `hresp` port, no ERR states, out-of-range handling as in Operation.

## Test plan
- Reset, then write 0xDEADBEEF to index 3 and read index 3 (WAIT_STATES=0) -> `hready` stays 1 and the read returns 0xDEADBEEF one cycle after its address phase.
- WAIT_STATES=2: write 0x11 to index 5 -> `hready` low for exactly 2 cycles and the write commits on the 3rd edge. Read back -> 0x11.
- Back-to-back write 0xA5A5A5A5 to index 7, then read index 7 with no idle between -> read returns 0xA5A5A5A5 through the forwarding path.
- Four consecutive writes to indices 0..3 (values 1..4) then four consecutive reads -> 1,2,3,4 at one per cycle.
- Assert `hresetn` during the WAIT state of a write of 0x55 to index 2 -> `hready`=1 immediately. Reading index 2 afterwards returns 0.
- With the macro, read index 20 (DEPTH=16) -> two-cycle ERROR response (`hready` 0 then 1, `hresp`=01). Without the macro -> OKAY and `hrdata`=0.
